// File: rtl/ahb_split_mem_slave_pkg.sv
// Shared constants for the split-capable AHB memory slave: transfer types,
// response codes, controller state encoding and the hsplit one-hot helper.
package ahb_split_mem_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DONE  = 3'd2,
    ST_RESP1 = 3'd3,
    ST_RESP2 = 3'd4
  } state_e;

  // Split-resume vector with a single bit set for the given master.
  function automatic logic [15:0] master_onehot(input logic [1:0] id);
    master_onehot = 16'h0001 << id;
  endfunction

endpackage

// File: rtl/ahb_split_mem_slave_if.sv
// AHB slave-side bus bundle for the split memory slave.
interface ahb_split_mem_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [1:0]  hmaster;
  logic [31:0] hrdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [15:0] hsplit;

  modport slave (
    input  hsel, haddr, hwrite, htrans, hwdata, hready_in, hmaster,
    output hrdata, hready_out, hresp, hsplit
  );

  modport master (
    output hsel, haddr, hwrite, htrans, hwdata, hmaster,
    input  hready_in, hrdata, hready_out, hresp, hsplit
  );
endinterface

// File: rtl/ahb_split_mem_slave_tracker.sv
// Split bookkeeping: one outstanding split at a time. Counts SPLIT_LAT cycles
// from the split response, pulses hsplit for the owning master, then holds a
// resume token until that master comes back. The slot stays busy (pending)
// from the split until the token is consumed so a second master cannot
// overwrite the first master's resume right.
module ahb_split_tracker
  import ahb_split_mem_slave_pkg::*;
#(
  parameter int SPLIT_LAT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_split_start,
  input  logic [1:0]  i_split_id,
  input  logic        i_token_clr,
  output logic        o_pending,
  output logic        o_token_valid,
  output logic [1:0]  o_token_id,
  output logic [15:0] o_hsplit
);

  localparam int            CW       = $clog2(SPLIT_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(SPLIT_LAT);
  localparam logic [CW-1:0] LAT_ONE  = CW'(1);

  logic          r_counting;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_id;
  logic          r_token_valid;
  logic [15:0]   r_hsplit;

  // Latency countdown, one-cycle resume pulse and token hand-off.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_counting    <= 1'b0;
      r_cnt         <= {CW{1'b0}};
      r_id          <= 2'b00;
      r_token_valid <= 1'b0;
      r_hsplit      <= 16'h0000;
    end else begin
      r_hsplit <= 16'h0000;
      if (r_counting) begin
        if (r_cnt == LAT_ONE) begin
          r_counting    <= 1'b0;
          r_hsplit      <= master_onehot(r_id);
          r_token_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - LAT_ONE;
        end
      end else if (i_split_start) begin
        r_counting <= 1'b1;
        r_cnt      <= LAT_INIT;
        r_id       <= i_split_id;
      end
      if (i_token_clr) begin
        r_token_valid <= 1'b0;
      end
    end
  end

  assign o_pending     = r_counting | r_token_valid;
  assign o_token_valid = r_token_valid;
  assign o_token_id    = r_id;
  assign o_hsplit      = r_hsplit;

endmodule

// File: rtl/ahb_split_mem_slave.sv
// Word-addressed AHB RAM slave with programmable wait states and
// ERROR / SPLIT / RETRY responses; split resume handled by ahb_split_tracker.
module ahb_split_mem_slave
  import ahb_split_mem_slave_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int SPLIT_BASE  = 128,
  parameter int SPLIT_LAT   = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ahb_split_mem_slave_if.slave  bus
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [AW:0] SPLIT_BASE_W = (AW + 1)'(SPLIT_BASE);
  localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_CYCLES - 1);
  localparam bit          HAS_WAIT     = (WAIT_CYCLES > 0);

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_nxt;
  logic [1:0]  r_code, w_code_nxt;
  logic [AW-1:0] r_word;
  logic        r_write;
  logic        r_hready;
  logic [1:0]  r_hresp;
  logic [31:0] r_hrdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept, w_err, w_high, w_token_hit;
  logic [AW-1:0] w_word, w_rd_word;
  logic          w_split_start, w_token_clr;
  logic          w_pending, w_token_valid;
  logic [1:0]    w_token_id;
  logic [15:0]   w_hsplit;
  logic          w_hready_nxt, w_mem_we, w_rd_load;
  logic [1:0]    w_hresp_nxt;
  logic [31:0]   w_rd_data;
  logic          w_unused_bits;

  assign w_accept    = bus.hsel & bus.htrans[1] & bus.hready_in;
  assign w_word      = bus.haddr[AW+1:2];
  assign w_err       = |bus.haddr[31:AW+2];
  assign w_high      = ({1'b0, w_word} >= SPLIT_BASE_W);
  assign w_token_hit = w_high & w_token_valid & (w_token_id == bus.hmaster);
  assign w_unused_bits = ^{bus.haddr[1:0], bus.htrans[0]};

  // Next-state selection: classify accepted address phases, sequence waits and responses.
  always_comb begin
    w_state_nxt   = ST_IDLE;
    w_wait_nxt    = r_wait_cnt;
    w_code_nxt    = r_code;
    w_split_start = 1'b0;
    w_token_clr   = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (r_wait_cnt == 4'h0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = r_wait_cnt - 4'h1;
        end
      end
      ST_RESP1: begin
        w_state_nxt = ST_RESP2;
      end
      ST_IDLE, ST_DONE, ST_RESP2: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_RESP1;
            w_code_nxt  = HRESP_ERROR;
          end else if (w_high && !w_token_hit) begin
            w_state_nxt = ST_RESP1;
            if (w_pending) begin
              w_code_nxt = HRESP_RETRY;
            end else begin
              w_code_nxt    = HRESP_SPLIT;
              w_split_start = 1'b1;
            end
          end else begin
            w_token_clr = w_token_hit;
            if (HAS_WAIT) begin
              w_state_nxt = ST_WAIT;
              w_wait_nxt  = WAIT_INIT;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_hready_nxt = (w_state_nxt != ST_WAIT) && (w_state_nxt != ST_RESP1);
  assign w_hresp_nxt  = ((w_state_nxt == ST_RESP1) || (w_state_nxt == ST_RESP2)) ? w_code_nxt : HRESP_OKAY;

  // Read data is fetched on the edge entering DONE; a write completing on the
  // same edge to the same word is forwarded so back-to-back W->R sees new data.
  assign w_mem_we  = (r_state == ST_DONE) & r_write;
  assign w_rd_word = w_accept ? w_word : r_word;
  assign w_rd_load = (w_state_nxt == ST_DONE) & !(w_accept ? bus.hwrite : r_write);
  assign w_rd_data = (w_mem_we && (r_word == w_rd_word)) ? bus.hwdata : r_mem[w_rd_word];

  // Controller state, registered bus outputs and latched address phase.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'h0;
      r_code     <= HRESP_OKAY;
      r_word     <= {AW{1'b0}};
      r_write    <= 1'b0;
      r_hready   <= 1'b1;
      r_hresp    <= HRESP_OKAY;
      r_hrdata   <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_code     <= w_code_nxt;
      r_hready   <= w_hready_nxt;
      r_hresp    <= w_hresp_nxt;
      if (w_accept) begin
        r_word  <= w_word;
        r_write <= bus.hwrite;
      end
      if (w_rd_load) begin
        r_hrdata <= w_rd_data;
      end
    end
  end

  // RAM write during the DONE data phase; a reset on that edge suppresses it.
  always_ff @(posedge hclk) begin
    if (hresetn && w_mem_we) begin
      r_mem[r_word] <= bus.hwdata;
    end
  end

  ahb_split_tracker #(.SPLIT_LAT(SPLIT_LAT)) u_tracker (
    .i_clk         (hclk),
    .i_rst_n       (hresetn),
    .i_split_start (w_split_start),
    .i_split_id    (bus.hmaster),
    .i_token_clr   (w_token_clr),
    .o_pending     (w_pending),
    .o_token_valid (w_token_valid),
    .o_token_id    (w_token_id),
    .o_hsplit      (w_hsplit)
  );

  assign bus.hrdata     = r_hrdata;
  assign bus.hready_out = r_hready;
  assign bus.hresp      = r_hresp;
  assign bus.hsplit     = w_hsplit;

endmodule
